memory_ctrl: RTL and testbench

MEMORY_CTRL -- requirements
Module: memory_ctrl

---
 rtl/memory_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_memory_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_ctrl.sv
// memory_ctrl
//   Arbitrates the CPU instruction bus (iBus) and data bus (dBus) onto three
//   memory regions selected by address[31:28]:
//     0x0 boot ROM   (synchronous, one-cycle read latency)
//     0x1 IO space   (single-cycle write strobe, combinational read data)
//     0x4 SDRAM      (16-bit controller, each 32-bit access split in halves)
//   Any other region is unmapped: reads return 0, writes are dropped.
//   dBus has priority when both buses request in the same IDLE cycle.
//
// Ports
//   clk_sys, reset_n            system clock, synchronous active-low reset
//   cpu_dBus_cmd_* / rsp_*      data bus command (read/write) and read response
//   cpu_iBus_cmd_* / rsp_*      instruction bus command (read only) and response
//   sdram_*                     16-bit SDRAM controller request/ack handshake
//   addr_o, bootrom_data_i      boot ROM address and registered read data
//   io_*                        IO write strobe, address, write and read data
module memory_ctrl (
  input  logic        clk_sys,
  input  logic        reset_n,

  input  logic        cpu_dBus_cmd_valid,
  output logic        cpu_dBus_cmd_ready,
  input  logic        cpu_dBus_cmd_payload_wr,
  input  logic [31:0] cpu_dBus_cmd_payload_address,
  input  logic [31:0] cpu_dBus_cmd_payload_data,
  input  logic [3:0]  cpu_dBus_cmd_payload_mask,
  input  logic [2:0]  cpu_dBus_cmd_payload_size,
  output logic        cpu_dBus_rsp_valid,
  output logic [31:0] cpu_dBus_rsp_payload_data,

  input  logic        cpu_iBus_cmd_valid,
  output logic        cpu_iBus_cmd_ready,
  input  logic [31:0] cpu_iBus_cmd_payload_address,
  input  logic [2:0]  cpu_iBus_cmd_payload_size,
  output logic        cpu_iBus_rsp_valid,
  output logic [31:0] cpu_iBus_rsp_payload_data,

  output logic        sdram_rd,
  output logic        sdram_wr,
  input  logic        sdram_rdy,
  input  logic        sdram_ack,
  output logic [23:0] sdram_addr_x16,
  output logic [15:0] sdram_wdata,
  input  logic [15:0] sdram_rdata,
  output logic [1:0]  sdram_wmask,

  output logic [31:0] addr_o,
  input  logic [31:0] bootrom_data_i,
  output logic        io_write_valid_o,
  output logic [31:0] io_addr_o,
  input  logic [31:0] io_rdata_i,
  output logic [31:0] io_wdata_o
);

  typedef enum logic [2:0] {
    IDLE, ROM_WAIT, IO_WAIT, SD_REQ_LO, SD_WAIT_LO, SD_REQ_HI, SD_WAIT_HI, RESP
  } state_t;

  typedef enum logic [1:0] {REG_ROM, REG_IO, REG_SD, REG_NONE} region_t;

  state_t      state, state_nxt;
  region_t     region_q, cmd_region;
  logic [31:0] addr_q, data_q, cmd_addr, resp_data;
  logic [3:0]  mask_q;
  logic        wr_q, src_ibus_q, cmd_wr;
  logic        accept_d, accept_i, accept;
  logic        sd_issue, sd_hi, resp_on;

  // Transfer size is implied by the mask; the size fields carry no information.
  logic unused_size;
  assign unused_size = ^{cpu_dBus_cmd_payload_size, cpu_iBus_cmd_payload_size};

  // Readiness is combinational on valid so a request is taken in the same
  // cycle it appears; dBus wins a tie. Gated by reset_n so nothing is
  // accepted while reset is held.
  always_comb begin
    accept_d = reset_n && (state == IDLE) && cpu_dBus_cmd_valid;
    accept_i = reset_n && (state == IDLE) && !cpu_dBus_cmd_valid && cpu_iBus_cmd_valid;
    accept   = accept_d || accept_i;
    cmd_addr = accept_d ? cpu_dBus_cmd_payload_address : cpu_iBus_cmd_payload_address;
    cmd_wr   = accept_d && cpu_dBus_cmd_payload_wr;
    case (cmd_addr[31:28])
      4'h0:    cmd_region = REG_ROM;
      4'h1:    cmd_region = REG_IO;
      4'h4:    cmd_region = REG_SD;
      default: cmd_region = REG_NONE;
    endcase
  end

  assign cpu_dBus_cmd_ready = accept_d;
  assign cpu_iBus_cmd_ready = accept_i;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // ROM and unmapped reads share ROM_WAIT: both need exactly one idle cycle
  // before the response. Writes to ROM or unmapped space are dropped in IDLE.
  always_comb begin
    state_nxt = state;
    sd_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_region)
            REG_IO:  state_nxt = IO_WAIT;
            REG_SD:  state_nxt = SD_REQ_LO;
            default: state_nxt = cmd_wr ? IDLE : ROM_WAIT;
          endcase
        end
      end
      ROM_WAIT: state_nxt = RESP;
      IO_WAIT:  state_nxt = wr_q ? IDLE : RESP;
      SD_REQ_LO: begin
        if (sdram_rdy) begin
          sd_issue  = 1'b1;
          state_nxt = SD_WAIT_LO;
        end
      end
      SD_WAIT_LO: if (sdram_ack) state_nxt = SD_REQ_HI;
      SD_REQ_HI: begin
        if (sdram_rdy) begin
          sd_issue  = 1'b1;
          state_nxt = SD_WAIT_HI;
        end
      end
      SD_WAIT_HI: if (sdram_ack) state_nxt = wr_q ? IDLE : RESP;
      RESP:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // The data register doubles as the SDRAM read assembly buffer: each ack of
  // a read fills the half currently being fetched.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      addr_q     <= '0;
      data_q     <= '0;
      mask_q     <= '0;
      wr_q       <= 1'b0;
      src_ibus_q <= 1'b0;
      region_q   <= REG_NONE;
    end else if (accept) begin
      addr_q     <= cmd_addr;
      data_q     <= accept_d ? cpu_dBus_cmd_payload_data : '0;
      mask_q     <= accept_d ? cpu_dBus_cmd_payload_mask : '0;
      wr_q       <= cmd_wr;
      src_ibus_q <= accept_i;
      region_q   <= cmd_region;
    end else if (!wr_q && sdram_ack) begin
      if (state == SD_WAIT_LO)      data_q[15:0]  <= sdram_rdata;
      else if (state == SD_WAIT_HI) data_q[31:16] <= sdram_rdata;
    end
  end

  assign sd_hi = (state == SD_REQ_HI) || (state == SD_WAIT_HI);

  // Every output is forced to zero while reset_n is low, independent of the
  // register contents before the first reset edge.
  assign sdram_rd       = reset_n && sd_issue && !wr_q;
  assign sdram_wr       = reset_n && sd_issue && wr_q;
  assign sdram_addr_x16 = reset_n ? {addr_q[24:2], sd_hi} : '0;
  assign sdram_wdata    = !reset_n ? '0 : (sd_hi ? data_q[31:16] : data_q[15:0]);
  assign sdram_wmask    = !reset_n ? '0 : (sd_hi ? mask_q[3:2] : mask_q[1:0]);

  assign addr_o           = reset_n ? addr_q : '0;
  assign io_addr_o        = reset_n ? addr_q : '0;
  assign io_wdata_o       = reset_n ? data_q : '0;
  assign io_write_valid_o = reset_n && (state == IO_WAIT) && wr_q;

  // ROM and IO data are taken live in RESP: the ROM output is valid one cycle
  // after addr_o settled, and IO read data follows io_addr_o.
  always_comb begin
    resp_on = reset_n && (state == RESP);
    case (region_q)
      REG_ROM: resp_data = bootrom_data_i;
      REG_IO:  resp_data = io_rdata_i;
      REG_SD:  resp_data = data_q;
      default: resp_data = '0;
    endcase
  end

  assign cpu_dBus_rsp_valid        = resp_on && !src_ibus_q;
  assign cpu_iBus_rsp_valid        = resp_on && src_ibus_q;
  assign cpu_dBus_rsp_payload_data = resp_on ? resp_data : '0;
  assign cpu_iBus_rsp_payload_data = resp_on ? resp_data : '0;

endmodule

// File: tb/tb_memory_ctrl.sv
// tb_memory_ctrl
//   Directed bench for memory_ctrl. Stimulus pushes each expected read
//   response (bus, data, cycle) into a queue; an independent monitor pops and
//   compares whenever either rsp_valid is seen. Behavioural ROM, IO and SDRAM
//   models sit on the memory side; the SDRAM model logs every write half.
module tb_memory_ctrl;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        cpu_dBus_cmd_valid, cpu_dBus_cmd_ready, cpu_dBus_cmd_payload_wr;
  logic [31:0] cpu_dBus_cmd_payload_address, cpu_dBus_cmd_payload_data;
  logic [3:0]  cpu_dBus_cmd_payload_mask;
  logic [2:0]  cpu_dBus_cmd_payload_size;
  logic        cpu_dBus_rsp_valid;
  logic [31:0] cpu_dBus_rsp_payload_data;
  logic        cpu_iBus_cmd_valid, cpu_iBus_cmd_ready;
  logic [31:0] cpu_iBus_cmd_payload_address;
  logic [2:0]  cpu_iBus_cmd_payload_size;
  logic        cpu_iBus_rsp_valid;
  logic [31:0] cpu_iBus_rsp_payload_data;
  logic        sdram_rd, sdram_wr, sdram_rdy, sdram_ack;
  logic [23:0] sdram_addr_x16;
  logic [15:0] sdram_wdata, sdram_rdata;
  logic [1:0]  sdram_wmask;
  logic [31:0] addr_o, bootrom_data_i, io_addr_o, io_rdata_i, io_wdata_o;
  logic        io_write_valid_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    bit          isIbus;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t expQ[$];

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  mask;
  } sdw_t;
  sdw_t sdLog[$];

  logic [15:0] sdMem [int];
  int ackDelay = 2;
  int rdyDelay = 1;
  int lastAckCyc = -100;
  int sdCmdCount = 0;

  memory_ctrl dut (
    .clk_sys(clk_sys), .reset_n(reset_n),
    .cpu_dBus_cmd_valid(cpu_dBus_cmd_valid), .cpu_dBus_cmd_ready(cpu_dBus_cmd_ready),
    .cpu_dBus_cmd_payload_wr(cpu_dBus_cmd_payload_wr),
    .cpu_dBus_cmd_payload_address(cpu_dBus_cmd_payload_address),
    .cpu_dBus_cmd_payload_data(cpu_dBus_cmd_payload_data),
    .cpu_dBus_cmd_payload_mask(cpu_dBus_cmd_payload_mask),
    .cpu_dBus_cmd_payload_size(cpu_dBus_cmd_payload_size),
    .cpu_dBus_rsp_valid(cpu_dBus_rsp_valid), .cpu_dBus_rsp_payload_data(cpu_dBus_rsp_payload_data),
    .cpu_iBus_cmd_valid(cpu_iBus_cmd_valid), .cpu_iBus_cmd_ready(cpu_iBus_cmd_ready),
    .cpu_iBus_cmd_payload_address(cpu_iBus_cmd_payload_address),
    .cpu_iBus_cmd_payload_size(cpu_iBus_cmd_payload_size),
    .cpu_iBus_rsp_valid(cpu_iBus_rsp_valid), .cpu_iBus_rsp_payload_data(cpu_iBus_rsp_payload_data),
    .sdram_rd(sdram_rd), .sdram_wr(sdram_wr), .sdram_rdy(sdram_rdy), .sdram_ack(sdram_ack),
    .sdram_addr_x16(sdram_addr_x16), .sdram_wdata(sdram_wdata), .sdram_rdata(sdram_rdata),
    .sdram_wmask(sdram_wmask),
    .addr_o(addr_o), .bootrom_data_i(bootrom_data_i), .io_write_valid_o(io_write_valid_o),
    .io_addr_o(io_addr_o), .io_rdata_i(io_rdata_i), .io_wdata_o(io_wdata_o)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // ROM: word 4 holds 0xDEADBEEF, every other word reads 0xB00C0000 | word.
  function automatic logic [31:0] romWord(input logic [31:0] a);
    if (a[31:2] == 30'd4) return 32'hDEADBEEF;
    return 32'hB00C0000 | (a >> 2);
  endfunction

  always @(posedge clk_sys) bootrom_data_i <= romWord(addr_o);
  assign io_rdata_i = io_addr_o ^ 32'hFFFF0000;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // SDRAM model: issue seen at negedge, rdy drops, ack after ackDelay cycles,
  // rdy returns rdyDelay cycles after ack.
  initial begin
    logic [15:0] old;
    logic [23:0] a;
    bit isRd;
    sdram_rdy = 1'b1;
    sdram_ack = 1'b0;
    sdram_rdata = '0;
    forever begin
      @(negedge clk_sys);
      if (reset_n && (sdram_rd || sdram_wr)) begin
        checkOutput("sd_rd_wr_exclusive", {31'd0, sdram_rd && sdram_wr}, 32'd0);
        checkOutput("sd_issue_when_rdy", {31'd0, sdram_rdy}, 32'd1);
        sdCmdCount++;
        a = sdram_addr_x16;
        isRd = sdram_rd;
        if (sdram_wr) begin
          old = sdMem.exists(int'(a)) ? sdMem[int'(a)] : 16'h0000;
          sdMem[int'(a)] = {sdram_wmask[1] ? sdram_wdata[15:8] : old[15:8],
                            sdram_wmask[0] ? sdram_wdata[7:0]  : old[7:0]};
          sdLog.push_back('{addr: a, data: sdram_wdata, mask: sdram_wmask});
        end
        @(posedge clk_sys); #1 sdram_rdy = 1'b0;
        repeat (ackDelay - 1) @(posedge clk_sys);
        #0;
        @(posedge clk_sys); #1;
        sdram_ack = 1'b1;
        sdram_rdata = (isRd && sdMem.exists(int'(a))) ? sdMem[int'(a)] : 16'h0000;
        lastAckCyc = cyc;
        @(posedge clk_sys); #1 sdram_ack = 1'b0;
        repeat (rdyDelay) @(posedge clk_sys);
        #1 sdram_rdy = 1'b1;
      end
    end
  end

  // Response monitor: every rsp_valid cycle must match the oldest expectation.
  always @(negedge clk_sys) begin
    exp_t e;
    if (reset_n === 1'b1) begin
      if (cpu_dBus_rsp_valid && cpu_iBus_rsp_valid)
        checkOutput("rsp_both_buses", 32'd1, 32'd0);
      else if (cpu_dBus_rsp_valid || cpu_iBus_rsp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("rsp_unexpected", {31'd0, cpu_iBus_rsp_valid}, 32'hFFFFFFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("rsp_bus_is_ibus", {31'd0, cpu_iBus_rsp_valid}, {31'd0, e.isIbus});
          checkOutput("rsp_data",
                      cpu_iBus_rsp_valid ? cpu_iBus_rsp_payload_data : cpu_dBus_rsp_payload_data,
                      e.data);
          if (e.cyc >= 0) checkOutput("rsp_cycle", cyc, e.cyc);
          else            checkOutput("rsp_cycle_after_ack", cyc, lastAckCyc + 1);
        end
      end
    end
  end

  // Issues one command and waits for acceptance; latency 2 = fixed T+2,
  // -1 = cycle after the final SDRAM ack.
  task automatic applyStimulus(input bit isIbus, input bit wr, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] mask,
                               input bit expectRsp, input logic [31:0] expData,
                               input int latency, output int tAcc);
    bit got = 0;
    tAcc = -1;
    if (isIbus) begin
      cpu_iBus_cmd_valid = 1'b1;
      cpu_iBus_cmd_payload_address = addr;
    end else begin
      cpu_dBus_cmd_valid = 1'b1;
      cpu_dBus_cmd_payload_wr = wr;
      cpu_dBus_cmd_payload_address = addr;
      cpu_dBus_cmd_payload_data = data;
      cpu_dBus_cmd_payload_mask = mask;
    end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_sys);
      if (isIbus ? cpu_iBus_cmd_ready : cpu_dBus_cmd_ready) begin
        got = 1;
        tAcc = cyc;
        if (expectRsp)
          expQ.push_back('{isIbus: isIbus, data: expData, cyc: (latency > 0) ? cyc + latency : -1});
      end
    end
    if (!got) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk_sys); #1;
    cpu_iBus_cmd_valid = 1'b0;
    cpu_dBus_cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && expQ.size() != 0; i++) @(posedge clk_sys);
    if (expQ.size() != 0) checkOutput("rsp_timeout", expQ.size(), 32'd0);
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic waitSdLog(input int n);
    for (int i = 0; i < 200 && sdLog.size() < n; i++) @(posedge clk_sys);
    checkOutput("sd_write_count", sdLog.size(), n);
    waitCycles(4);
  endtask

  initial begin
    int tA, tI, cnt0;
    bit got;
    reset_n = 1'b0;
    cpu_dBus_cmd_valid = 0; cpu_dBus_cmd_payload_wr = 0; cpu_dBus_cmd_payload_address = 0;
    cpu_dBus_cmd_payload_data = 0; cpu_dBus_cmd_payload_mask = 0; cpu_dBus_cmd_payload_size = 3'd2;
    cpu_iBus_cmd_valid = 0; cpu_iBus_cmd_payload_address = 0; cpu_iBus_cmd_payload_size = 3'd2;

    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys);
    checkOutput("reset_dready", {31'd0, cpu_dBus_cmd_ready}, 32'd0);
    checkOutput("reset_iready", {31'd0, cpu_iBus_cmd_ready}, 32'd0);
    checkOutput("reset_rsp", {30'd0, cpu_dBus_rsp_valid, cpu_iBus_rsp_valid}, 32'd0);
    checkOutput("reset_sd_cmd", {30'd0, sdram_rd, sdram_wr}, 32'd0);
    checkOutput("reset_io_wr", {31'd0, io_write_valid_o}, 32'd0);
    checkOutput("reset_addr_o", addr_o, 32'd0);
    checkOutput("reset_sd_addr", {8'd0, sdram_addr_x16}, 32'd0);
    @(posedge clk_sys); #1 reset_n = 1'b1;
    waitCycles(1);

    $display("[TB] ROM reads");
    applyStimulus(1, 0, 32'h0000_0010, 0, 0, 1, 32'hDEADBEEF, 2, tA);
    @(negedge clk_sys);
    checkOutput("rom_addr_t1", addr_o, 32'h0000_0010);
    waitDrain();
    applyStimulus(0, 0, 32'h0000_0020, 0, 0, 1, 32'hB00C0008, 2, tA);
    waitDrain();
    applyStimulus(0, 1, 32'h0000_0030, 32'h12345678, 4'hF, 0, 0, 0, tA);
    waitCycles(4);

    $display("[TB] IO access");
    applyStimulus(0, 1, 32'h1000_0004, 32'h00FF0000, 4'hF, 0, 0, 0, tA);
    @(negedge clk_sys);
    checkOutput("io_wr_valid_t1", {31'd0, io_write_valid_o}, 32'd1);
    checkOutput("io_addr_t1", io_addr_o, 32'h1000_0004);
    checkOutput("io_wdata_t1", io_wdata_o, 32'h00FF0000);
    @(negedge clk_sys);
    checkOutput("io_wr_valid_t2", {31'd0, io_write_valid_o}, 32'd0);
    waitCycles(3);
    applyStimulus(0, 0, 32'h1000_0040, 0, 0, 1, 32'hEFFF0040, 2, tA);
    @(negedge clk_sys);
    checkOutput("io_rd_addr_t1", io_addr_o, 32'h1000_0040);
    waitDrain();

    $display("[TB] SDRAM writes");
    ackDelay = 2; rdyDelay = 1;
    sdLog.delete();
    applyStimulus(0, 1, 32'h4000_0008, 32'hA5A5_1234, 4'hF, 0, 0, 0, tA);
    waitSdLog(2);
    if (sdLog.size() == 2) begin
      checkOutput("sdw0_addr", {8'd0, sdLog[0].addr}, 32'h0000_0004);
      checkOutput("sdw0_data", {16'd0, sdLog[0].data}, 32'h0000_1234);
      checkOutput("sdw0_mask", {30'd0, sdLog[0].mask}, 32'd3);
      checkOutput("sdw1_addr", {8'd0, sdLog[1].addr}, 32'h0000_0005);
      checkOutput("sdw1_data", {16'd0, sdLog[1].data}, 32'h0000_A5A5);
      checkOutput("sdw1_mask", {30'd0, sdLog[1].mask}, 32'd3);
    end
    sdLog.delete();
    applyStimulus(0, 1, 32'h4000_000C, 32'h1122_3344, 4'b0100, 0, 0, 0, tA);
    waitSdLog(2);
    if (sdLog.size() == 2) begin
      checkOutput("sdw_pm0_addr", {8'd0, sdLog[0].addr}, 32'h0000_0006);
      checkOutput("sdw_pm0_mask", {30'd0, sdLog[0].mask}, 32'd0);
      checkOutput("sdw_pm1_addr", {8'd0, sdLog[1].addr}, 32'h0000_0007);
      checkOutput("sdw_pm1_data", {16'd0, sdLog[1].data}, 32'h0000_1122);
      checkOutput("sdw_pm1_mask", {30'd0, sdLog[1].mask}, 32'd1);
    end

    $display("[TB] SDRAM reads");
    ackDelay = 3; rdyDelay = 2;
    applyStimulus(0, 0, 32'h4000_0008, 0, 0, 1, 32'hA5A5_1234, -1, tA);
    waitDrain();
    applyStimulus(1, 0, 32'h4000_000C, 0, 0, 1, 32'h0022_0000, -1, tA);
    waitDrain();

    $display("[TB] arbitration");
    cpu_dBus_cmd_valid = 1; cpu_dBus_cmd_payload_wr = 0;
    cpu_dBus_cmd_payload_address = 32'h2000_0000;
    cpu_iBus_cmd_valid = 1; cpu_iBus_cmd_payload_address = 32'h0000_0010;
    @(negedge clk_sys);
    checkOutput("arb_dready", {31'd0, cpu_dBus_cmd_ready}, 32'd1);
    checkOutput("arb_iready", {31'd0, cpu_iBus_cmd_ready}, 32'd0);
    tA = cyc;
    expQ.push_back('{isIbus: 1'b0, data: 32'h0, cyc: tA + 2});
    @(posedge clk_sys); #1 cpu_dBus_cmd_valid = 0;
    got = 0; tI = -1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk_sys);
      if (cpu_iBus_cmd_ready) begin
        got = 1;
        tI = cyc;
        expQ.push_back('{isIbus: 1'b1, data: 32'hDEADBEEF, cyc: cyc + 2});
      end
    end
    checkOutput("arb_ibus_accept_cycle", tI, tA + 3);
    @(posedge clk_sys); #1 cpu_iBus_cmd_valid = 0;
    waitDrain();

    $display("[TB] unmapped and reset abort");
    applyStimulus(0, 0, 32'h2000_0000, 0, 0, 1, 32'h0, 2, tA);
    waitDrain();
    applyStimulus(0, 1, 32'h8000_0000, 32'hFFFFFFFF, 4'hF, 0, 0, 0, tA);
    waitCycles(4);
    ackDelay = 6; rdyDelay = 1;
    cnt0 = sdCmdCount;
    applyStimulus(0, 0, 32'h4000_0020, 0, 0, 0, 0, 0, tA);
    for (int i = 0; i < 20 && sdCmdCount == cnt0; i++) @(posedge clk_sys);
    checkOutput("abort_lo_issued", sdCmdCount, cnt0 + 1);
    @(posedge clk_sys); #1;
    reset_n = 0;
    cpu_dBus_cmd_valid = 1; cpu_dBus_cmd_payload_address = 32'h2000_0000;
    @(negedge clk_sys);
    checkOutput("abort_dready", {31'd0, cpu_dBus_cmd_ready}, 32'd0);
    checkOutput("abort_addr_o", addr_o, 32'd0);
    checkOutput("abort_sd_cmd", {30'd0, sdram_rd, sdram_wr}, 32'd0);
    @(posedge clk_sys); #1;
    @(posedge clk_sys); #1;
    cpu_dBus_cmd_valid = 0;
    reset_n = 1;
    waitCycles(12);
    checkOutput("abort_no_hi_issue", sdCmdCount, cnt0 + 1);
    applyStimulus(0, 0, 32'h3000_0004, 0, 0, 1, 32'h0, 2, tA);
    waitDrain();

    checkOutput("queue_empty", expQ.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish (checks %0d)", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
